// File: rtl/gpioemu_op_queue.sv
// Bus-programmed operand queue for the multiply/popcount engine; a push is visible on op_* one edge later, and a pop on the same edge keeps the level unchanged.
// Backpressure: op_ready low holds the head entry. A push into a full queue with no pop is dropped, and overflow latches until software writes STAT.
module gpioemu_op_queue #(
  parameter int DEPTH = 4,
  parameter logic [15:0] ADDR_A1 = 16'h03B0,
  parameter logic [15:0] ADDR_A2 = 16'h03B4,
  parameter logic [15:0] ADDR_PUSH = 16'h03B8,
  parameter logic [15:0] ADDR_STAT = 16'h03BC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] saddress,
  input  logic        swr,
  input  logic        srd,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [23:0] op_a1,
  output logic [23:0] op_a2,
  output logic [7:0]  fifo_level,
  output logic        overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [23:0] a1;
    logic [23:0] a2;
  } op_t;

  op_t         mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [7:0]  level;
  logic [23:0] stage_a1, stage_a2;

  logic full, empty, pop, push_cmd, push_ok, push_drop, stat_clr;
  logic unused_sdata_hi;

  assign unused_sdata_hi = ^sdata_in[31:24];

  assign full      = (level == 8'(DEPTH));
  assign empty     = (level == 8'd0);
  assign pop       = op_valid && op_ready;
  assign push_cmd  = swr && (saddress == ADDR_PUSH);
  // A full queue still accepts a push when the head leaves on the same edge.
  assign push_ok   = push_cmd && (!full || pop);
  assign push_drop = push_cmd && full && !pop;
  assign stat_clr  = swr && (saddress == ADDR_STAT);

  assign op_valid   = !empty;
  assign op_a1      = mem[rptr].a1;
  assign op_a2      = mem[rptr].a2;
  assign fifo_level = level;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= 8'd0;
      overflow  <= 1'b0;
      stage_a1  <= 24'd0;
      stage_a2  <= 24'd0;
      sdata_out <= 32'd0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (swr && saddress == ADDR_A1) stage_a1 <= sdata_in[23:0];
      if (swr && saddress == ADDR_A2) stage_a2 <= sdata_in[23:0];

      if (push_ok) begin
        mem[wptr] <= '{a1: stage_a1, a2: stage_a2};
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);

      case ({push_ok, pop})
        2'b10:   level <= level + 8'd1;
        2'b01:   level <= level - 8'd1;
        default: level <= level;
      endcase

      // A dropped push takes priority over a simultaneous clear.
      if (push_drop)     overflow <= 1'b1;
      else if (stat_clr) overflow <= 1'b0;

      if (srd) begin
        case (saddress)
          ADDR_STAT: sdata_out <= {21'h0, overflow, full, empty, level};
          ADDR_A1:   sdata_out <= {8'h0, stage_a1};
          ADDR_A2:   sdata_out <= {8'h0, stage_a2};
          default:   sdata_out <= 32'h0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gpioemu_op_queue.sv
// Directed bench for gpioemu_op_queue: reset state, push/pop ordering, overflow, full-with-pop, reset discard.
module tb_gpioemu_op_queue;

  localparam logic [15:0] A_A1   = 16'h03B0;
  localparam logic [15:0] A_A2   = 16'h03B4;
  localparam logic [15:0] A_PUSH = 16'h03B8;
  localparam logic [15:0] A_STAT = 16'h03BC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] saddress = 16'h0;
  logic        swr = 1'b0;
  logic        srd = 1'b0;
  logic [31:0] sdata_in = 32'h0;
  logic [31:0] sdata_out;
  logic        op_valid;
  logic        op_ready = 1'b0;
  logic [23:0] op_a1, op_a2;
  logic [7:0]  fifo_level;
  logic        overflow;

  int total = 0;
  int passed = 0;

  gpioemu_op_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .saddress(saddress), .swr(swr), .srd(srd),
    .sdata_in(sdata_in), .sdata_out(sdata_out), .op_valid(op_valid),
    .op_ready(op_ready), .op_a1(op_a1), .op_a2(op_a2),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
    saddress = a; sdata_in = d; swr = 1'b1;
    tick();
    swr = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a);
    saddress = a; srd = 1'b1;
    tick();
    srd = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  initial begin
    logic [23:0] drain_exp [4];
    drain_exp[0] = 24'd2; drain_exp[1] = 24'd3; drain_exp[2] = 24'd4; drain_exp[3] = 24'd9;

    // Reset state
    tick(); tick();
    reset = 1'b0;
    chk("rst_valid", 32'(op_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_a1", 32'(op_a1), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    bus_rd(A_STAT);
    chk("rst_stat", sdata_out, 32'h0000_0100);

    // Single push; upper data bits ignored on staging
    bus_wr(A_A1, 32'hAB00_0003);
    bus_wr(A_A2, 32'h0000_0005);
    bus_wr(A_PUSH, 32'hDEAD_BEEF);
    chk("push1_valid", 32'(op_valid), 32'd1);
    chk("push1_a1", 32'(op_a1), 32'd3);
    chk("push1_a2", 32'(op_a2), 32'd5);
    chk("push1_level", 32'(fifo_level), 32'd1);
    bus_rd(A_A1);
    chk("rd_a1", sdata_out, 32'h0000_0003);
    tick();
    chk("rd_hold", sdata_out, 32'h0000_0003);
    bus_rd(16'h03C0);
    chk("rd_other", sdata_out, 32'h0);

    // Single pop empties the queue
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    chk("pop1_level", 32'(fifo_level), 32'd0);
    chk("pop1_valid", 32'(op_valid), 32'd0);

    // Five pushes into DEPTH=4: last one dropped
    for (int i = 1; i <= 5; i++) begin
      bus_wr(A_A1, 32'(i));
      bus_wr(A_PUSH, 32'h0);
    end
    chk("ovf_level", 32'(fifo_level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_head", 32'(op_a1), 32'd1);
    bus_rd(A_STAT);
    chk("ovf_stat", sdata_out, 32'h0000_0604);
    bus_wr(A_STAT, 32'h0);
    bus_rd(A_STAT);
    chk("clr_stat", sdata_out, 32'h0000_0204);

    // Push into full queue with simultaneous pop
    bus_wr(A_A1, 32'd9);
    op_ready = 1'b1;
    bus_wr(A_PUSH, 32'h0);
    op_ready = 1'b0;
    chk("fullpop_level", 32'(fifo_level), 32'd4);
    chk("fullpop_ovf", 32'(overflow), 32'd0);
    chk("fullpop_head", 32'(op_a1), 32'd2);

    // Drain in order
    op_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d_valid", k), 32'(op_valid), 32'd1);
      chk($sformatf("drain%0d_a1", k), 32'(op_a1), 32'(drain_exp[k]));
      chk($sformatf("drain%0d_a2", k), 32'(op_a2), 32'd5);
      tick();
    end
    op_ready = 1'b0;
    chk("drained_valid", 32'(op_valid), 32'd0);
    chk("drained_level", 32'(fifo_level), 32'd0);
    bus_rd(A_STAT);
    chk("drained_stat", sdata_out, 32'h0000_0100);

    // Reset discards queued entries and staging
    bus_wr(A_PUSH, 32'h0);
    bus_wr(A_PUSH, 32'h0);
    chk("pre_rst_level", 32'(fifo_level), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", 32'(op_valid), 32'd0);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_a1", 32'(op_a1), 32'd0);
    bus_rd(A_STAT);
    chk("mid_rst_stat", sdata_out, 32'h0000_0100);
    bus_rd(A_A1);
    chk("mid_rst_stage", sdata_out, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
